phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Four-phase time-slot scheduler that owns a programmable 5-bit duration timer and steps through phases 0→1→2→3, holding each phase for a software-set number of clock cycles. It is the control layer over the terminal-count timer: it supplies the per-phase count limit, clears the timer on phase entry, and freezes it on hold. Typical consumers are lamp or multiplexed-display drivers and other fixed-schedule sequencers.

## Interface
- No parameters. Widths are fixed: 5-bit durations, 4 phases.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a sequence; sampled only in IDLE.
- hold  in  1  level; freezes the timer and the current phase while high.
- abort  in  1  level/pulse; returns to IDLE without asserting done.
- loop  in  1  level; 1 = wrap from phase 3 to phase 0 instead of finishing.
- dur0, dur1, dur2, dur3  in  5 each  per-phase duration; phase k lasts dur_k+1 run cycles.
- busy  out  1  high in RUN or PAUSE.
- phase  out  2  current phase index; 0 in IDLE.
- phase_oh  out  4  one-hot phase; 4'b0000 in IDLE.
- done  out  1  one-cycle pulse at sequence completion.
- paused  out  1  high in PAUSE.

## Operation
- States: IDLE, RUN, PAUSE.
- Event priority: rst > abort > hold > timer terminal > start.
- IDLE + start=1:
  - Snapshot dur0..dur3 into internal limit registers.
  - Next state RUN, phase=0.
  - Timer cleared to 0.
- RUN: the timer increments each cycle. Terminal is cnt >= limit[phase] (5-bit unsigned compare). On terminal:
  - phase < 3: phase+1 and timer cleared.
  - phase = 3 and loop=1: phase=0, timer cleared, limits re-snapshotted from dur inputs.
  - phase = 3 and loop=0: go to IDLE and pulse done for one cycle.
- RUN + hold=1: go to PAUSE. The timer does not advance in that cycle and no terminal is taken.
- PAUSE:
  - The timer and phase are frozen.
  - hold=0 returns to RUN, and counting resumes from the frozen value.
  - Paused cycles do not count toward the duration.
- abort=1 in any state: IDLE next cycle, timer cleared, done=0.
- start while busy: ignored. start and abort together in IDLE: stay in IDLE.
- Changing dur inputs mid-sequence has no effect until the next start or loop wrap.
- dur=0 gives a 1-cycle phase. dur=31 gives a 32-cycle phase, and the counter never wraps past 31.
- Outputs are registered and derived from state and phase only. There are no combinational paths from inputs to outputs.

## Timing
- Reset values: busy=0, phase=0, phase_oh=0000, done=0, paused=0, timer=0, limits=0.
- start sampled high at edge n: busy=1, phase=0, phase_oh=0001 from cycle n+1.
- Phase k occupies exactly dur_k+1 consecutive RUN cycles.
- Non-loop sequence with no hold: busy lasts Σ(dur_k+1) cycles.
  - done=1 and busy=0 in the cycle immediately after the last phase-3 cycle.
- A hold asserted for h cycles during RUN extends the sequence by exactly h cycles.
- abort sampled at edge m: busy=0 from cycle m+1.
- rst mid-sequence behaves like abort, and additionally clears the limit registers.
- After done, start may be asserted in the same cycle done is high (state is IDLE). The new sequence starts on the next cycle.

## Structure
- Shared package holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2);
  - NPHASE=4 and DUR_W=5.
- One sub-module, phase_timer.
  - Ports: clk, rst, clr, en, limit[4:0], term.
  - cnt clears on rst or clr; otherwise it increments when en=1.
  - term = (cnt >= limit), combinational.
- The controller drives clr on phase entry and abort, and en = (state==RUN).

## Test plan
- Basic run: dur=1,2,0,3, loop=0, start pulse → phase_oh 0001×2, 0010×3, 0100×1, 1000×4, then done=1 for 1 cycle, busy=0.
- Hold: dur all 4, hold high for 3 cycles during phase 1 → paused=1 for those 3 cycles, phase stays 1, total busy = 23 cycles.
- Loop: dur all 0, loop=1 → phase cycles 0,1,2,3,0,1… every cycle, no done; then loop=0 → done follows the next phase-3 cycle.
- Abort: abort during phase 2 → busy=0 and phase_oh=0000 next cycle, done never asserted; a following start begins at phase 0 with a fresh count.
- Snapshot: change dur0 from 5 to 1 during phase 0 → phase 0 still lasts 6 cycles; a start while busy is ignored.
- Boundaries: dur0=31 → phase 0 lasts 32 cycles. Synchronous rst mid-PAUSE → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// phase_sequencer_pkg: shared FSM state codes and fixed widths for the phase sequencer
package phase_sequencer_pkg;
  localparam int NPHASE = 4;
  localparam int DUR_W = 5;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
endpackage

// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: control inputs (start/hold/abort/loop/dur0..3) and status outputs (busy/phase/phase_oh/done/paused)
interface phase_sequencer_if;
  import phase_sequencer_pkg::*;
  logic start, hold, abort, loop;
  logic [DUR_W-1:0] dur0, dur1, dur2, dur3;
  logic busy, done, paused;
  logic [1:0] phase;
  logic [NPHASE-1:0] phase_oh;
  modport master(output start, hold, abort, loop, dur0, dur1, dur2, dur3, input busy, phase, phase_oh, done, paused);
  modport slave(input start, hold, abort, loop, dur0, dur1, dur2, dur3, output busy, phase, phase_oh, done, paused);
endinterface

// File: rtl/phase_sequencer_timer.sv
// phase_timer: 5-bit saturating duration counter (clk, rst, clr, en, limit in; term = cnt >= limit out)
module phase_timer
  import phase_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DUR_W-1:0] limit,
  output logic             term
);
  logic [DUR_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (en && cnt != '1) ? cnt + 1'b1 : cnt;
  assign term = cnt >= limit;
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: four-phase slot scheduler (clk, rst, sif.slave: start/hold/abort/loop/dur0..3 in; busy/phase/phase_oh/done/paused out)
module phase_sequencer
  import phase_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  phase_sequencer_if.slave sif
);
  logic [1:0] state, nstate, ph, nph;
  logic [DUR_W-1:0] lim [NPHASE];
  logic clr, snap, fin, term, busy_w, en;
  assign busy_w = state != IDLE;
  assign en = busy_w && !sif.hold;
  phase_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .limit(lim[ph]),
    .term (term)
  );
  // The release cycle of PAUSE (hold low) counts as a run cycle, so h hold cycles cost exactly h cycles.
  always_comb begin
    nstate = state;
    nph = ph;
    clr = 1'b0;
    snap = 1'b0;
    fin = 1'b0;
    if (sif.abort) begin
      nstate = IDLE;
      nph = '0;
      clr = 1'b1;
    end else if (!busy_w) begin
      if (sif.start) begin
        nstate = RUN;
        nph = '0;
        clr = 1'b1;
        snap = 1'b1;
      end
    end else if (sif.hold) begin
      nstate = PAUSE;
    end else begin
      nstate = RUN;
      if (term) begin
        clr = 1'b1;
        nph = ph + 1'b1;
        snap = ph == 2'd3 && sif.loop;
        if (ph == 2'd3 && !sif.loop) begin
          nstate = IDLE;
          fin = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ph <= '0;
      sif.done <= 1'b0;
      lim <= '{default: '0};
    end else begin
      state <= nstate;
      ph <= nph;
      sif.done <= fin;
      if (snap) lim <= '{sif.dur0, sif.dur1, sif.dur2, sif.dur3};
    end
  end
  assign sif.busy = busy_w;
  assign sif.paused = state == PAUSE;
  assign sif.phase = ph;
  assign sif.phase_oh = busy_w ? NPHASE'(1) << ph : '0;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed stimulus, per-cycle check against a remaining-cycles schedule model, plus literal checks
module tb_phase_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  phase_sequencer_if bus ();
  phase_sequencer dut (.clk(clk), .rst(rst), .sif(bus));
  always #5 clk = ~clk;

  bit m_busy, m_paused, m_done;
  int m_phase, m_rem;
  int ml[4];
  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_busy = 0; m_paused = 0; m_phase = 0; m_rem = 0; ml = '{0, 0, 0, 0};
    end else if (bus.abort) begin
      m_busy = 0; m_paused = 0; m_phase = 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        ml = '{int'(bus.dur0), int'(bus.dur1), int'(bus.dur2), int'(bus.dur3)};
        m_busy = 1; m_phase = 0; m_rem = ml[0] + 1;
      end
    end else if (bus.hold) begin
      m_paused = 1;
    end else begin
      m_paused = 0;
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        if (m_phase < 3) begin
          m_phase = m_phase + 1; m_rem = ml[m_phase] + 1;
        end else if (bus.loop) begin
          ml = '{int'(bus.dur0), int'(bus.dur1), int'(bus.dur2), int'(bus.dur3)};
          m_phase = 0; m_rem = ml[0] + 1;
        end else begin
          m_busy = 0; m_phase = 0; m_done = 1;
        end
      end
    end
  end

  int n_chk = 0, n_fail = 0;
  int bcnt = 0, dcnt = 0, pau = 0;
  int pcnt[4] = '{0, 0, 0, 0};
  int s_b, s_d, s_pa;
  int s_p[4];
  bit ob_busy, ob_paused;
  logic [3:0] ob_oh;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    int eoh;
    @(negedge clk);
    eoh = m_busy ? (1 << m_phase) : 0;
    chk("busy", int'(bus.busy), int'(m_busy));
    chk("paused", int'(bus.paused), int'(m_paused));
    chk("phase", int'(bus.phase), m_busy ? m_phase : 0);
    chk("phase_oh", int'(bus.phase_oh), eoh);
    chk("done", int'(bus.done), int'(m_done));
    ob_busy = bus.busy; ob_paused = bus.paused; ob_oh = bus.phase_oh;
    bcnt += int'(bus.busy); dcnt += int'(bus.done); pau += int'(bus.paused);
    if (bus.busy) pcnt[bus.phase]++;
    @(posedge clk); #1;
  endtask

  task automatic snap_ctr();
    s_b = bcnt; s_d = dcnt; s_pa = pau; s_p = pcnt;
  endtask

  task automatic set_dur(input int a, input int b, input int c, input int d);
    bus.dur0 = 5'(a); bus.dur1 = 5'(b); bus.dur2 = 5'(c); bus.dur3 = 5'(d);
  endtask

  task automatic go();
    bus.start = 1; tick(); bus.start = 0;
  endtask

  task automatic wait_idle(input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      tick();
      if (!ob_busy) break;
    end
    chk("idle_timeout", int'(i < lim), 1);
  endtask

  initial begin
    bus.start = 0; bus.hold = 0; bus.abort = 0; bus.loop = 0;
    set_dur(0, 0, 0, 0);
    @(posedge clk); #1;
    tick(); tick();
    chk("rst_busy", int'(ob_busy), 0);
    chk("rst_oh", int'(ob_oh), 0);
    rst = 0;
    tick();

    set_dur(1, 2, 0, 3); snap_ctr(); go(); wait_idle(30);
    chk("basic_busy", bcnt - s_b, 10);
    chk("basic_p0", pcnt[0] - s_p[0], 2);
    chk("basic_p1", pcnt[1] - s_p[1], 3);
    chk("basic_p2", pcnt[2] - s_p[2], 1);
    chk("basic_p3", pcnt[3] - s_p[3], 4);
    chk("basic_done", dcnt - s_d, 1);
    tick();

    set_dur(4, 4, 4, 4); snap_ctr(); go();
    repeat (6) tick();
    bus.hold = 1; repeat (3) tick(); bus.hold = 0;
    wait_idle(40);
    chk("hold_busy", bcnt - s_b, 23);
    chk("hold_paused", pau - s_pa, 3);
    chk("hold_p1", pcnt[1] - s_p[1], 8);

    set_dur(0, 0, 0, 0); bus.loop = 1; snap_ctr(); go();
    repeat (10) tick();
    chk("loop_nodone", dcnt - s_d, 0);
    chk("loop_busy", int'(ob_busy), 1);
    bus.loop = 0; snap_ctr(); wait_idle(10);
    chk("loop_done", dcnt - s_d, 1);

    set_dur(2, 2, 2, 2); snap_ctr(); go();
    repeat (7) tick();
    bus.abort = 1; tick(); bus.abort = 0; tick();
    chk("abort_busy", int'(ob_busy), 0);
    chk("abort_oh", int'(ob_oh), 0);
    chk("abort_done", dcnt - s_d, 0);
    snap_ctr(); go(); wait_idle(20);
    chk("abort_restart_p0", pcnt[0] - s_p[0], 3);

    bus.start = 1; bus.abort = 1; tick(); bus.start = 0; bus.abort = 0; tick();
    chk("start_abort_idle", int'(ob_busy), 0);

    set_dur(5, 0, 0, 0); snap_ctr(); go();
    bus.dur0 = 5'd1; bus.start = 1; tick(); tick(); bus.start = 0;
    wait_idle(30);
    chk("snap_p0", pcnt[0] - s_p[0], 6);
    chk("snap_busy", bcnt - s_b, 9);

    set_dur(31, 0, 0, 0); snap_ctr(); go(); wait_idle(60);
    chk("dur31_p0", pcnt[0] - s_p[0], 32);

    set_dur(3, 3, 3, 3); go(); tick(); tick();
    bus.hold = 1; tick(); tick();
    chk("pause_before_rst", int'(ob_paused), 1);
    rst = 1; tick(); rst = 0; bus.hold = 0; tick();
    chk("rst_pause_busy", int'(ob_busy), 0);
    chk("rst_pause_paused", int'(ob_paused), 0);
    chk("rst_pause_oh", int'(ob_oh), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
